// File: rtl/stl_pkg.sv
// Shared constants for the stl stage library: the two buffering modes of stl_skid_reg.
package stl_pkg;

    localparam int STL_MODE_PIPE = 0;
    localparam int STL_MODE_SKID = 1;

endpackage

// File: rtl/stl_sreg.sv
// One data entry: a WIDTH-bit register with synchronous active-high reset and write enable.
module stl_sreg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge i_clk) begin
        // NOTE: state is written with <= so every flop samples pre-edge values; = here would race.
        if (i_rst) begin
            o_q <= RESET_VAL;
        end else if (i_we) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/stl_skid_reg.sv
// Valid/ready register slice: a two-entry skid buffer with registered ready (SKID=1)
// or a single-entry pipe stage with pass-through ready (SKID=0). Output is always the main entry.
module stl_skid_reg
    import stl_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               SKID      = STL_MODE_SKID
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_pre_valid,
    output logic             o_pre_ready,
    input  logic [WIDTH-1:0] i_pre_data,
    output logic             o_post_valid,
    input  logic             i_post_ready,
    output logic [WIDTH-1:0] o_post_data,
    output logic [1:0]       o_count
);

    localparam bit HAS_SKID = (SKID == STL_MODE_SKID);

    logic             main_valid;
    logic             main_valid_d;
    logic             main_we;
    logic [WIDTH-1:0] main_d;
    logic             skid_valid;
    logic             skid_valid_d;
    logic             skid_we;
    logic [WIDTH-1:0] skid_q;
    logic             push;
    logic             pop;

    assign push = i_pre_valid & o_pre_ready;
    assign pop  = main_valid & i_post_ready;

    // Ready is forced low during reset so no handshake is acknowledged while state is being cleared.
    generate
        if (HAS_SKID) begin : g_skid
            assign o_pre_ready = ~skid_valid & ~i_rst;

            stl_sreg #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_skid_reg (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .i_we  (skid_we),
                .i_d   (i_pre_data),
                .o_q   (skid_q)
            );

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    skid_valid <= 1'b0;
                end else begin
                    skid_valid <= skid_valid_d;
                end
            end
        end else begin : g_pipe
            assign o_pre_ready = (~main_valid | i_post_ready) & ~i_rst;
            assign skid_valid  = 1'b0;
            assign skid_q      = RESET_VAL;
        end
    endgenerate

    // Flush only clears valid flags; data registers keep their contents.
    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        main_valid_d = main_valid;
        skid_valid_d = skid_valid;
        main_we      = 1'b0;
        skid_we      = 1'b0;
        main_d       = i_pre_data;
        if (i_flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop && skid_valid) begin
            main_we      = 1'b1;
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end else if (push && (!main_valid || pop)) begin
            main_we      = 1'b1;
            main_valid_d = 1'b1;
        end else if (push) begin
            skid_we      = 1'b1;
            skid_valid_d = 1'b1;
        end else if (pop) begin
            main_valid_d = 1'b0;
        end
    end

    stl_sreg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_we  (main_we),
        .i_d   (main_d),
        .o_q   (o_post_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            main_valid <= 1'b0;
        end else begin
            main_valid <= main_valid_d;
        end
    end

    // Skid is only ever occupied behind a valid main entry, so the count is a direct encoding.
    assign o_post_valid = main_valid;
    assign o_count      = {skid_valid, main_valid & ~skid_valid};

endmodule

// File: tb/tb_stl_skid_reg.sv
// Bench for stl_skid_reg: a pipe-mode (index 0) and a skid-mode (index 1) instance run side by side
// against a queue-based model of the stage; directed scenarios first, then randomized traffic.
module tb_stl_skid_reg;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       pv  [2];
    logic [7:0] pd  [2];
    logic       pr  [2];
    logic       fl  [2];
    logic       rdy [2];
    logic       ov  [2];
    logic [7:0] od  [2];
    logic [1:0] cnt [2];

    int checks   = 0;
    int failures = 0;

    // Model: each stage is a FIFO of capacity 2 (skid) or 1 (pipe) plus the last presented value.
    logic [7:0] mq    [2][2];
    int         msize [2];
    logic [7:0] mlast [2];

    always #5 clk = ~clk;

    stl_skid_reg #(.WIDTH(W), .RESET_VAL(RV), .SKID(0)) u_pipe (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (fl[0]),
        .i_pre_valid  (pv[0]),
        .o_pre_ready  (rdy[0]),
        .i_pre_data   (pd[0]),
        .o_post_valid (ov[0]),
        .i_post_ready (pr[0]),
        .o_post_data  (od[0]),
        .o_count      (cnt[0])
    );

    stl_skid_reg #(.WIDTH(W), .RESET_VAL(RV), .SKID(1)) u_skid (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (fl[1]),
        .i_pre_valid  (pv[1]),
        .o_pre_ready  (rdy[1]),
        .i_pre_data   (pd[1]),
        .o_post_valid (ov[1]),
        .i_post_ready (pr[1]),
        .o_post_data  (od[1]),
        .o_count      (cnt[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready(input int m);
        if (rst) return 1'b0;
        if (m == 1) return msize[m] < 2;
        return (msize[m] == 0) || pr[m];
    endfunction

    task automatic model_edge(input int m);
        bit do_pop;
        bit do_push;
        if (rst) begin
            msize[m] = 0;
            mlast[m] = RV;
            return;
        end
        do_pop  = (msize[m] > 0) && pr[m];
        do_push = pv[m] && exp_ready(m);
        if (fl[m]) begin
            msize[m] = 0;
        end else begin
            if (do_pop) begin
                mq[m][0] = mq[m][1];
                msize[m]--;
            end
            if (do_push) begin
                mq[m][msize[m]] = pd[m];
                msize[m]++;
            end
        end
        if (msize[m] > 0) mlast[m] = mq[m][0];
    endtask

    task automatic set_in(input int m, input logic v, input logic [7:0] d, input logic r, input logic f);
        pv[m] = v;
        pd[m] = d;
        pr[m] = r;
        fl[m] = f;
    endtask

    // Check both stages against the model mid-cycle, then advance one clock.
    task automatic cycle();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("m%0d_ready", m), rdy[m], exp_ready(m));
            check($sformatf("m%0d_valid", m), ov[m], msize[m] > 0);
            check($sformatf("m%0d_data", m), od[m], (msize[m] > 0) ? mq[m][0] : mlast[m]);
            check($sformatf("m%0d_count", m), cnt[m], msize[m]);
        end
        for (int m = 0; m < 2; m++) model_edge(m);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int m = 0; m < 2; m++) set_in(m, 1'b1, 8'h3C, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            msize[m] = 0;
            mlast[m] = RV;
        end

        // Reset held two cycles with upstream offering data.
        check("rst_ready_pipe", rdy[0], 1'b0);
        check("rst_ready_skid", rdy[1], 1'b0);
        cycle();
        cycle();
        rst = 1'b0;
        for (int m = 0; m < 2; m++) set_in(m, 1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        for (int m = 0; m < 2; m++) begin
            check("post_rst_valid", ov[m], 1'b0);
            check("post_rst_data", od[m], 8'hA5);
            check("post_rst_count", cnt[m], 2'd0);
            check("post_rst_ready", rdy[m], 1'b1);
        end

        // Streaming 1..4 with downstream always ready.
        for (int k = 1; k <= 4; k++) begin
            for (int m = 0; m < 2; m++) set_in(m, 1'b1, 8'(k), 1'b1, 1'b0);
            cycle();
            for (int m = 0; m < 2; m++) begin
                check("stream_data", od[m], k);
                check("stream_count", cnt[m], 2'd1);
            end
        end
        for (int m = 0; m < 2; m++) set_in(m, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle();

        // Backpressure on the skid stage.
        set_in(1, 1'b1, 8'd10, 1'b0, 1'b0);
        cycle();
        set_in(1, 1'b1, 8'd11, 1'b0, 1'b0);
        cycle();
        set_in(1, 1'b0, 8'd0, 1'b0, 1'b0);
        #1;
        check("bp_count_full", cnt[1], 2'd2);
        check("bp_ready_full", rdy[1], 1'b0);
        check("bp_head", od[1], 8'd10);
        set_in(1, 1'b0, 8'd0, 1'b1, 1'b0);
        cycle();
        check("bp_ready_after_pop", rdy[1], 1'b1);
        check("bp_second", od[1], 8'd11);
        cycle();
        check("bp_drained", cnt[1], 2'd0);

        // Flush with two entries held, a push of 99 and a pop in the same cycle.
        set_in(1, 1'b1, 8'd20, 1'b0, 1'b0);
        cycle();
        set_in(1, 1'b1, 8'd21, 1'b0, 1'b0);
        cycle();
        set_in(1, 1'b1, 8'd99, 1'b1, 1'b1);
        cycle();
        set_in(1, 1'b0, 8'd0, 1'b1, 1'b0);
        #1;
        check("flush_count", cnt[1], 2'd0);
        check("flush_valid", ov[1], 1'b0);
        check("flush_ready", rdy[1], 1'b1);
        check("flush_data_kept", od[1], 8'd20);
        cycle();
        cycle();

        // Pipe stage: entry held, downstream ready, new push accepted in the same cycle.
        set_in(0, 1'b1, 8'd5, 1'b0, 1'b0);
        cycle();
        set_in(0, 1'b1, 8'd7, 1'b1, 1'b0);
        #1;
        check("pipe_ready_passthru", rdy[0], 1'b1);
        cycle();
        check("pipe_next_data", od[0], 8'd7);
        check("pipe_next_valid", ov[0], 1'b1);
        set_in(0, 1'b0, 8'd0, 1'b1, 1'b0);
        cycle();

        // Randomized traffic on both stages, with occasional flush and reset.
        for (int c = 0; c < 10000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int m = 0; m < 2; m++) begin
                set_in(m, ($urandom_range(0, 3) != 0), 8'($urandom),
                       ($urandom_range(0, 1) == 1), ($urandom_range(0, 63) == 0));
            end
            cycle();
        end

        // Reset with both skid entries occupied discards everything.
        rst = 1'b0;
        set_in(1, 1'b1, 8'd40, 1'b0, 1'b0);
        cycle();
        set_in(1, 1'b1, 8'd41, 1'b0, 1'b0);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_in(1, 1'b0, 8'd0, 1'b1, 1'b0);
        #1;
        check("midrst_count", cnt[1], 2'd0);
        check("midrst_data", od[1], 8'hA5);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stl_skid_reg.md
STL_SKID_REG -- requirements
Module: stl_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (>=1).
REQ-002 SHALL have parameter RESET_VAL, default 0, value loaded into every data register on reset.
REQ-003 SHALL have parameter SKID, default 1; 1 = two-entry skid stage with registered o_pre_ready, 0 = single-entry pipe stage with combinational o_pre_ready.
REQ-004 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_flush  input  1  synchronous discard of all held entries.
REQ-007 i_pre_valid  input  1  upstream offers i_pre_data.
REQ-008 o_pre_ready  output  1  stage accepts upstream data this cycle.
REQ-009 i_pre_data  input  WIDTH  upstream payload.
REQ-010 o_post_valid  output  1  o_post_data holds a valid entry.
REQ-011 i_post_ready  input  1  downstream accepts this cycle.
REQ-012 o_post_data  output  WIDTH  payload of oldest entry.
REQ-013 o_count  output  2  entries held (0..2; max 1 when SKID=0).

Function
REQ-014 Push = i_pre_valid & o_pre_ready; pop = o_post_valid & i_post_ready; each SHALL move exactly one entry.
REQ-015 Data SHALL be delivered in strict FIFO order, never duplicated, never dropped except by flush/reset.
REQ-016 Latency SHALL be 1 cycle: data pushed in cycle N is on o_post_data with o_post_valid=1 in cycle N+1.
REQ-017 Throughput SHALL be one entry per cycle in both modes while i_post_ready=1.
REQ-018 o_post_valid and o_post_data SHALL be driven only from registers (main entry).
REQ-019 SKID=1: o_pre_ready SHALL equal !skid_valid, a registered signal with no combinational path from i_post_ready.
REQ-020 SKID=1: push with main empty, or main full and pop, SHALL write main; push with main full and no pop SHALL write skid.
REQ-021 SKID=1: pop with skid valid SHALL move skid into main and clear skid in the same edge.
REQ-022 SKID=0: o_pre_ready SHALL equal !main_valid | i_post_ready; skid storage SHALL not exist.
REQ-023 Simultaneous push and pop with one entry held SHALL keep o_count unchanged and replace main.
REQ-024 When empty, o_post_data SHALL retain its last value; consumers treat it as don't-care.
REQ-025 Flush: at the next edge all valid flags SHALL clear (o_count=0); a push in the flush cycle SHALL be discarded; a pop in the flush cycle SHALL complete normally.
REQ-026 Flush SHALL not alter data registers; o_pre_ready in the cycle after flush SHALL be 1.
REQ-027 Upstream SHALL hold i_pre_valid/i_pre_data stable until push; the block SHALL not depend on this for correctness of its own state.

Reset
REQ-028 i_rst=1 at an edge SHALL clear all valid flags and load RESET_VAL into all data registers, overriding flush, push and pop.
REQ-029 After reset: o_post_valid=0, o_count=0, o_post_data=RESET_VAL, o_pre_ready=1 (SKID=1) or 1 (SKID=0).
REQ-030 While i_rst=1, o_pre_ready SHALL be 0 so no push is acknowledged during reset.
REQ-031 Reset mid-transfer SHALL discard both entries with no partial update.

Structure
REQ-032 Mode constants (STL_MODE_PIPE=0, STL_MODE_SKID=1) SHALL live in shared package stl_pkg; no other typedefs required.
REQ-033 One sub-module stl_sreg (WIDTH, RESET_VAL; sync active-high reset, write enable) SHALL be instantiated per data entry; control logic stays in stl_skid_reg.

Verification
REQ-034 Reset: assert i_rst 2 cycles with i_pre_valid=1, RESET_VAL=8'hA5 -> o_pre_ready=0 during reset; after: o_post_valid=0, o_post_data=8'hA5, o_count=0.
REQ-035 Streaming: push 1,2,3,4 back-to-back, i_post_ready=1 -> outputs 1,2,3,4 on cycles N+1..N+4, o_count stays 1.
REQ-036 Backpressure (SKID=1): push 10,11 with i_post_ready=0 -> o_count=2, o_pre_ready=0; release -> 10 then 11, o_pre_ready=1 the cycle after 10 pops.
REQ-037 Flush: hold 2 entries, assert i_flush with push of 99 and i_post_ready=1 -> current main pops, next cycle o_count=0, 99 never appears.
REQ-038 SKID=0: entry held, i_post_ready=1, push 7 -> o_pre_ready=1 same cycle, 7 on output next cycle.
REQ-039 Random valid/ready for 10k cycles both modes -> scoreboard order/no-loss match, o_count matches model every cycle.
